wb_arbiter2: RTL and testbench
==============================

Name: wb_arbiter2

Overview:
Two-master, one-slave Wishbone arbiter that shares the SDRAM Wishbone slave port between the FSMC bridge (master 0) and a second on-chip master (master 1, e.g. capture/DMA).
- Grant is registered and round-robin.
- The grant is held for the whole of the owning master's cyc assertion, so multi-beat transfers are never split.
- Sits between the bus masters and the SDRAM controller in the top level.

Parameters:
AW, 24, Wishbone address width
DW, 32, Wishbone data width
SW, 4, byte-select width (DW/8)
TIMEOUT, 255, cycles a granted strobe may wait for ack before abort (used only with WB_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
m0_adr_i, m1_adr_i  in  AW  master address
m0_dat_i, m1_dat_i  in  DW  master write data
m0_sel_i, m1_sel_i  in  SW  master byte selects
m0_cyc_i, m1_cyc_i  in  1  master cycle request
m0_stb_i, m1_stb_i  in  1  master strobe
m0_we_i, m1_we_i  in  1  master write enable
m0_dat_o, m1_dat_o  out  DW  read data (s_dat_i broadcast to both)
m0_ack_o, m1_ack_o  out  1  ack, gated to owner only
m0_err_o, m1_err_o  out  1  timeout abort, gated to owner only
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  SW  slave byte selects
s_cyc_o, s_stb_o, s_we_o  out  1  slave control
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
gnt_o  out  2  one-hot current owner; 00 = idle

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - gnt_o=00, state=IDLE, last=1 (so master 0 wins the first tie), timeout counter=0.
  - s_cyc_o=0, s_stb_o=0, s_we_o=0; all acks and errs 0.
  - s_adr_o, s_dat_o and s_sel_o are driven from master 0 while idle.
- States:
  - IDLE: no owner.
  - GNT0: master 0 owns the slave.
  - GNT1: master 1 owns the slave.
- IDLE transitions (evaluated each clock):
  - only m0_cyc_i -> GNT0; only m1_cyc_i -> GNT1.
  - both asserted -> grant the master that is not last.
  - Entering GNTn sets last=n.
- GNTn hold:
  - Stay while mn_cyc_i=1.
  - On mn_cyc_i=0, go directly to GNT(other) if the other master's cyc is high, else IDLE.
  - The owner may never be pre-empted while its cyc is high.
- Latency:
  - Grant is registered, so s_cyc_o rises 1 cycle after the winning cyc is sampled.
  - s_cyc_o and s_stb_o fall in the same cycle the owner drops cyc (combinational mux qualified by state).
- Datapath:
  - s_adr/dat/sel/we/stb/cyc = owner's signals when in GNTn.
  - s_cyc_o and s_stb_o are forced to 0 in IDLE.
- Acks and data:
  - mn_ack_o = s_ack_i & (state==GNTn).
  - The non-owner never sees an ack, even if s_ack_i glitches high in IDLE.
  - mN_dat_o = s_dat_i unconditionally.
- Handover: back-to-back handover gives 0 idle cycles between owners; the new owner's strobe is presented in the first cycle after the previous owner's cyc falls.
- Owner strobe idle: an owner holding cyc=1 with stb=0 keeps the grant; the other master waits indefinitely (no timeout counting while stb=0).
- Mid-transfer reset: rst asserted mid-transfer returns to IDLE immediately and drops s_cyc_o and s_stb_o asynchronously; last returns to 1.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- Enabled:
  - An 8..16-bit counter clears on grant change and on s_ack_i, and increments while the owner holds stb=1 without ack.
  - When the counter reaches TIMEOUT:
    - pulse mn_err_o to the owner for 1 cycle;
    - force s_cyc_o=0 for that cycle;
    - go to GNT(other) if the other master requests, else IDLE, and set last=n.
  - The owner must drop cyc after err; re-requests are arbitrated normally.
- Disabled: no counter logic; m0_err_o=m1_err_o=0 constant.

Test Plan:
1. Reset, then m0 only: m0 write to 0x000010, data 0xDEADBEEF, sel=F; slave acks 2 cycles later -> gnt_o=01 one cycle after cyc; s_adr_o=0x000010; m0_ack_o pulses 1 cycle; m1_ack_o=0; IDLE after cyc drops.
2. m0 and m1 both assert cyc in the same cycle after reset -> m0 granted first; on m0 cyc drop, gnt_o goes 01->10 with no IDLE cycle; next simultaneous request grants m0 again (round robin).
3. m1 holds cyc for a 4-beat read (slave returns 0x1,0x2,0x3,0x4) while m0 requests at beat 1 -> m1 keeps the grant for all 4 acks; m0 is granted only after m1 cyc=0; m0_ack_o stays 0 throughout.
4. rst asserted during m1 stb with no ack -> s_cyc_o and s_stb_o go 0 without a clock edge; gnt_o=00; after release, a simultaneous request grants m0.
5. Slave ack forced high while in IDLE -> m0_ack_o=m1_ack_o=0.
6. WB_ARB_TIMEOUT_EN with TIMEOUT=8: m0 strobes, slave never acks -> m0_err_o pulses in the 8th stalled cycle; grant released; pending m1 granted next cycle. Without the macro: m0 stalls forever and err stays 0.

Source files
------------

// File: rtl/wb_arbiter2_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2_if
// Description : Wishbone signal bundle for the two-master / one-slave arbiter.
//               The "slave" modport is the arbiter's view: it receives the
//               two masters' requests and the SDRAM responses. The "master"
//               modport is the view of the surrounding masters and SDRAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter2_if #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int SW = 4
);
  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i;
  logic          m0_cyc_i, m1_cyc_i;
  logic          m0_stb_i, m1_stb_i;
  logic          m0_we_i,  m1_we_i;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m1_ack_o;
  logic          m0_err_o, m1_err_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i;
  logic [1:0]    gnt_o;

  modport slave (
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    input  m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
    input  s_dat_i, s_ack_i,
    output gnt_o
  );

  modport master (
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    output m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
    output s_dat_i, s_ack_i,
    input  gnt_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter2
// Description : Two-master, one-slave Wishbone arbiter sharing the SDRAM port
//               between the FSMC bridge (master 0) and a second on-chip
//               master (master 1). Registered round-robin grant, held for the
//               owner's whole cyc assertion.
//               Optional macro WB_ARB_TIMEOUT_EN adds a strobe-to-ack timeout
//               that aborts the owner with a one-cycle err pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int SW = 4
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic          clk,
  input  logic          rst,
  wb_arbiter2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, next_state;
  logic          last, next_last;   // master granted most recently
  logic          timeout;           // owner's strobe has waited too long
  logic [AW-1:0] adr_mux;
  logic [DW-1:0] dat_mux;
  logic [SW-1:0] sel_mux;
  logic          cyc_mux, stb_mux, we_mux;

  // State and round-robin pointer; last=1 lets master 0 win the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      last  <= next_last;
    end
  end

  // Next-state: owner keeps the slave until it drops cyc (or times out)
  always_comb begin
    next_state = state;
    next_last  = last;
    case (state)
      IDLE: begin
        if (bus.m0_cyc_i && bus.m1_cyc_i) next_state = last ? GNT0 : GNT1;
        else if (bus.m0_cyc_i)            next_state = GNT0;
        else if (bus.m1_cyc_i)            next_state = GNT1;
      end
      GNT0: if (!bus.m0_cyc_i || timeout) next_state = bus.m1_cyc_i ? GNT1 : IDLE;
      GNT1: if (!bus.m1_cyc_i || timeout) next_state = bus.m0_cyc_i ? GNT0 : IDLE;
      default: next_state = IDLE;
    endcase
    if (next_state == GNT0 && state != GNT0) next_last = 1'b0;
    if (next_state == GNT1 && state != GNT1) next_last = 1'b1;
  end

  // Slave-side mux: master 0 addresses/data by default, controls low in IDLE
  always_comb begin
    adr_mux = bus.m0_adr_i;
    dat_mux = bus.m0_dat_i;
    sel_mux = bus.m0_sel_i;
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    we_mux  = 1'b0;
    case (state)
      GNT0: begin
        cyc_mux = bus.m0_cyc_i;
        stb_mux = bus.m0_stb_i;
        we_mux  = bus.m0_we_i;
      end
      GNT1: begin
        adr_mux = bus.m1_adr_i;
        dat_mux = bus.m1_dat_i;
        sel_mux = bus.m1_sel_i;
        cyc_mux = bus.m1_cyc_i;
        stb_mux = bus.m1_stb_i;
        we_mux  = bus.m1_we_i;
      end
      default: ;
    endcase
  end

  assign bus.s_adr_o  = adr_mux;
  assign bus.s_dat_o  = dat_mux;
  assign bus.s_sel_o  = sel_mux;
  assign bus.s_cyc_o  = cyc_mux & ~timeout;   // abort cycle on timeout
  assign bus.s_stb_o  = stb_mux;
  assign bus.s_we_o   = we_mux;
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_ack_o = bus.s_ack_i & (state == GNT0);
  assign bus.m1_ack_o = bus.s_ack_i & (state == GNT1);
  assign bus.gnt_o    = {state == GNT1, state == GNT0};

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CLOG_T = $clog2(TIMEOUT + 1);
  localparam int CNT_W  = (CLOG_T < 8) ? 8 : ((CLOG_T > 16) ? 16 : CLOG_T);

  logic [CNT_W-1:0] wait_cnt;
  logic             owner_stb;

  assign owner_stb = (state == GNT0 && bus.m0_cyc_i && bus.m0_stb_i) ||
                     (state == GNT1 && bus.m1_cyc_i && bus.m1_stb_i);
  // Fires in the TIMEOUT-th consecutive stalled strobe cycle
  assign timeout   = owner_stb & ~bus.s_ack_i & (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Stall counter: restarts on every ack and every change of owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     wait_cnt <= '0;
    else if (next_state != state || bus.s_ack_i) wait_cnt <= '0;
    else if (owner_stb)                          wait_cnt <= wait_cnt + 1'b1;
  end

  assign bus.m0_err_o = timeout & (state == GNT0);
  assign bus.m1_err_o = timeout & (state == GNT1);
`else
  assign timeout      = 1'b0;
  assign bus.m0_err_o = 1'b0;
  assign bus.m1_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter2
// Description : Self-checking bench for wb_arbiter2. Expected read data and
//               write addresses are queued when stimulus is driven and
//               popped when the owner's ack appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  wb_arbiter2_if #(.AW(24), .DW(32), .SW(4)) bus ();

`ifdef WB_ARB_TIMEOUT_EN
  wb_arbiter2 #(.AW(24), .DW(32), .SW(4), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  wb_arbiter2 #(.AW(24), .DW(32), .SW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.m0_adr_i = '0; bus.m1_adr_i = '0; bus.m0_dat_i = '0; bus.m1_dat_i = '0;
    bus.m0_sel_i = '0; bus.m1_sel_i = '0; bus.m0_cyc_i = 0; bus.m1_cyc_i = 0;
    bus.m0_stb_i = 0;  bus.m1_stb_i = 0;  bus.m0_we_i = 0;  bus.m1_we_i = 0;
    bus.s_dat_i = '0;  bus.s_ack_i = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b00) begin miscompares++; $display("FAIL rst_gnt: got %b want 00", bus.gnt_o); end
    vectors++; if ({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o} !== 3'b000) begin miscompares++; $display("FAIL rst_ctrl: got %b want 000", {bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}); end
    vectors++; if ({bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o} !== 4'b0000) begin miscompares++; $display("FAIL rst_ackerr: got %b want 0000", {bus.m0_ack_o, bus.m1_ack_o, bus.m0_err_o, bus.m1_err_o}); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk);
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_we_i = 1;
    bus.m0_adr_i = 24'h000010; bus.m0_dat_i = 32'hDEADBEEF; bus.m0_sel_i = 4'hF;
    exp_q.push_back(32'h000010);
    #1;
    vectors++; if (bus.gnt_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL t1_latency: gnt %b cyc %b want 00 0", bus.gnt_o, bus.s_cyc_o); end
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b01) begin miscompares++; $display("FAIL t1_gnt: got %b want 01", bus.gnt_o); end
    vectors++; if (bus.s_adr_o !== 24'h000010 || bus.s_dat_o !== 32'hDEADBEEF || bus.s_sel_o !== 4'hF || bus.s_we_o !== 1'b1 || bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1)
      begin miscompares++; $display("FAIL t1_mux: adr %h dat %h sel %h we %b cyc %b stb %b", bus.s_adr_o, bus.s_dat_o, bus.s_sel_o, bus.s_we_o, bus.s_cyc_o, bus.s_stb_o); end
    @(negedge clk); bus.s_ack_i = 1; #1;
    exp = exp_q.pop_front();
    vectors++; if (bus.m0_ack_o !== 1'b1 || bus.m1_ack_o !== 1'b0) begin miscompares++; $display("FAIL t1_ack: m0 %b m1 %b want 1 0", bus.m0_ack_o, bus.m1_ack_o); end
    vectors++; if ({8'h00, bus.s_adr_o} !== exp) begin miscompares++; $display("FAIL t1_sb_adr: got %h want %h", bus.s_adr_o, exp); end
    @(negedge clk); bus.s_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0; bus.m0_we_i = 0; #1;
    vectors++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || bus.m0_ack_o !== 1'b0) begin miscompares++; $display("FAIL t1_drop: cyc %b stb %b ack %b want 0 0 0", bus.s_cyc_o, bus.s_stb_o, bus.m0_ack_o); end
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b00) begin miscompares++; $display("FAIL t1_idle: got %b want 00", bus.gnt_o); end
  endtask

  task automatic test_round_robin();
    pulse_reset(); drive_idle();
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m0_adr_i = 24'h000100;
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 24'h000200;
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b01 || bus.s_adr_o !== 24'h000100) begin miscompares++; $display("FAIL t2_first: gnt %b adr %h want 01 000100", bus.gnt_o, bus.s_adr_o); end
    @(negedge clk); bus.s_ack_i = 1; bus.s_dat_i = 32'h000000A0; exp_q.push_back(32'h000000A0); #1;
    exp = exp_q.pop_front();
    vectors++; if (bus.m0_ack_o !== 1'b1 || bus.m1_ack_o !== 1'b0 || bus.m0_dat_o !== exp) begin miscompares++; $display("FAIL t2_ack0: ack %b%b dat %h want 10 %h", bus.m0_ack_o, bus.m1_ack_o, bus.m0_dat_o, exp); end
    @(negedge clk); bus.s_ack_i = 0; bus.m0_cyc_i = 0; bus.m0_stb_i = 0; #1;
    vectors++; if (bus.gnt_o !== 2'b01 || bus.s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL t2_drop0: gnt %b cyc %b want 01 0", bus.gnt_o, bus.s_cyc_o); end
    @(negedge clk); bus.s_ack_i = 1; bus.s_dat_i = 32'h000000B0; exp_q.push_back(32'h000000B0); #1;
    exp = exp_q.pop_front();
    vectors++; if (bus.gnt_o !== 2'b10 || bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 24'h000200) begin miscompares++; $display("FAIL t2_handover: gnt %b cyc %b adr %h want 10 1 000200", bus.gnt_o, bus.s_cyc_o, bus.s_adr_o); end
    vectors++; if (bus.m1_ack_o !== 1'b1 || bus.m0_ack_o !== 1'b0 || bus.m1_dat_o !== exp) begin miscompares++; $display("FAIL t2_ack1: ack %b%b dat %h want 01 %h", bus.m0_ack_o, bus.m1_ack_o, bus.m1_dat_o, exp); end
    @(negedge clk); bus.s_ack_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0;
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b00) begin miscompares++; $display("FAIL t2_idle: got %b want 00", bus.gnt_o); end
    bus.m0_cyc_i = 1; bus.m1_cyc_i = 1;
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b01) begin miscompares++; $display("FAIL t2_rr: got %b want 01", bus.gnt_o); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_burst();
    pulse_reset(); drive_idle();
    bus.m1_cyc_i = 1; bus.m1_stb_i = 1; bus.m1_adr_i = 24'h000300;
    bus.m0_adr_i = 24'h000400;
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b10) begin miscompares++; $display("FAIL t3_gnt: got %b want 10", bus.gnt_o); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.s_ack_i = 1; bus.s_dat_i = 32'(i); exp_q.push_back(32'(i));
      if (i == 1) begin bus.m0_cyc_i = 1; bus.m0_stb_i = 1; end
      #1;
      exp = exp_q.pop_front();
      vectors++; if (bus.m1_ack_o !== 1'b1 || bus.m1_dat_o !== exp || bus.m0_ack_o !== 1'b0 || bus.gnt_o !== 2'b10)
        begin miscompares++; $display("FAIL t3_beat%0d: ack %b%b dat %h gnt %b want 01 %h 10", i, bus.m0_ack_o, bus.m1_ack_o, bus.m1_dat_o, bus.gnt_o, exp); end
    end
    @(negedge clk); bus.s_ack_i = 0; bus.m1_cyc_i = 0; bus.m1_stb_i = 0; #1;
    vectors++; if (bus.gnt_o !== 2'b10 || bus.m0_ack_o !== 1'b0 || bus.s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL t3_release: gnt %b ack0 %b cyc %b want 10 0 0", bus.gnt_o, bus.m0_ack_o, bus.s_cyc_o); end
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b01 || bus.s_adr_o !== 24'h000400) begin miscompares++; $display("FAIL t3_m0_next: gnt %b adr %h want 01 000400", bus.gnt_o, bus.s_adr_o); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    drive_idle();
    @(negedge clk);
    @(negedge clk); bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b10 || bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1) begin miscompares++; $display("FAIL t4_pre: gnt %b cyc %b stb %b want 10 1 1", bus.gnt_o, bus.s_cyc_o, bus.s_stb_o); end
    #1; rst = 1'b1; #1;
    vectors++; if (bus.gnt_o !== 2'b00 || bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin miscompares++; $display("FAIL t4_async: gnt %b cyc %b stb %b want 00 0 0", bus.gnt_o, bus.s_cyc_o, bus.s_stb_o); end
    @(negedge clk); rst = 1'b0; bus.m0_cyc_i = 1; bus.m0_stb_i = 1;
    @(negedge clk); #1;
    vectors++; if (bus.gnt_o !== 2'b01) begin miscompares++; $display("FAIL t4_after: got %b want 01", bus.gnt_o); end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_idle_ack();
    drive_idle();
    bus.m0_adr_i = 24'h000055; bus.m1_adr_i = 24'h0000AA;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.s_ack_i = 1; bus.s_dat_i = 32'h12345678; #1;
      vectors++; if (bus.m0_ack_o !== 1'b0 || bus.m1_ack_o !== 1'b0 || bus.gnt_o !== 2'b00 || bus.s_cyc_o !== 1'b0)
        begin miscompares++; $display("FAIL t5_idle_ack: ack %b%b gnt %b cyc %b want 00 00 0", bus.m0_ack_o, bus.m1_ack_o, bus.gnt_o, bus.s_cyc_o); end
      vectors++; if (bus.s_adr_o !== 24'h000055 || bus.m0_dat_o !== 32'h12345678 || bus.m1_dat_o !== 32'h12345678)
        begin miscompares++; $display("FAIL t5_idle_mux: adr %h dat %h/%h want 000055 12345678", bus.s_adr_o, bus.m0_dat_o, bus.m1_dat_o); end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    pulse_reset(); drive_idle();
    @(negedge clk);
    bus.m0_cyc_i = 1; bus.m0_stb_i = 1; bus.m1_cyc_i = 1; bus.m1_stb_i = 1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      vectors++; if (bus.gnt_o !== 2'b01 || bus.m0_err_o !== (k == 8) || bus.s_cyc_o !== (k != 8) || bus.m1_err_o !== 1'b0)
        begin miscompares++; $display("FAIL t6_stall%0d: gnt %b err %b%b cyc %b", k, bus.gnt_o, bus.m0_err_o, bus.m1_err_o, bus.s_cyc_o); end
    end
    @(negedge clk); bus.m0_cyc_i = 0; bus.m0_stb_i = 0; #1;
    vectors++; if (bus.gnt_o !== 2'b10 || bus.m0_err_o !== 1'b0) begin miscompares++; $display("FAIL t6_handover: gnt %b err %b want 10 0", bus.gnt_o, bus.m0_err_o); end
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      vectors++; if (bus.gnt_o !== 2'b01 || bus.m0_err_o !== 1'b0 || bus.m1_err_o !== 1'b0 || bus.s_cyc_o !== 1'b1)
        begin miscompares++; $display("FAIL t6_stall%0d: gnt %b err %b%b cyc %b want 01 00 1", k, bus.gnt_o, bus.m0_err_o, bus.m1_err_o, bus.s_cyc_o); end
    end
`endif
    drive_idle();
    @(negedge clk);
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single_write();
    test_round_robin();
    test_burst();
    test_async_reset();
    test_idle_ack();
    test_timeout();
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL sb_empty: %0d entries left want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
